// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request sequencer.
// Forms the redirect target from a jump or a taken branch. Jump has priority over branch.
// Issues fetch requests with a valid/ready handshake.
// A redirect that arrives while a request waits is held until that request is accepted.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] offset_shifted,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        misaligned_q, misaligned_d;

  logic        redirect;
  logic        jump_misaligned;
  logic [31:0] redirect_target;

  // Redirect target: a jump is forced to word alignment. A branch sum wraps modulo 2^32.
  always_comb begin
    redirect        = jump | branch_taken;
    jump_misaligned = jump & (jump_target[1:0] != 2'b00);
    redirect_target = jump ? {jump_target[31:2], 2'b00} : (branch_base + offset_shifted);
  end

  // Next-state, next-pc and pending-redirect selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    misaligned_d  = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        // No request is outstanding, so a redirect goes directly into pc.
        if (redirect) begin
          pc_d         = redirect_target;
          misaligned_d = jump_misaligned;
        end
        state_d = stall ? StHold : StFetch;
      end
      StFetch: begin
        if (!imem_ready) begin
          // The request must stay stable. The oldest redirect is parked; later ones are dropped.
          if (redirect && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
            misaligned_d  = jump_misaligned;
          end
        end else begin
          if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else if (redirect) begin
            pc_d         = redirect_target;
            misaligned_d = jump_misaligned;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          pend_valid_d = 1'b0;
          state_d      = stall ? StHold : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers. Reset clears all pending state asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0000_0000;
      pend_valid_q  <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_valid = (state_q == StFetch);
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios, then randomized traffic.
// Checks are made against a behavioural fetch model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [31:0] offset_shifted;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an address plus "request outstanding" and one parked redirect.
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_pend;
  logic [31:0] m_pend_t;
  logic        m_mis;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_base    (branch_base),
    .offset_shifted (offset_shifted),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_pend_t = 32'h0;
    m_mis  = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        red;
    logic        bad;
    red = jump | branch_taken;
    bad = jump && (jump_target % 4 != 0);
    tgt = jump ? (jump_target / 4) * 4 : branch_base + offset_shifted;
    m_mis = 1'b0;
    if (!m_busy) begin
      if (red) begin
        m_pc  = tgt;
        m_mis = bad;
      end
      m_busy = !stall;
    end else if (!imem_ready) begin
      if (red && !m_pend) begin
        m_pend   = 1'b1;
        m_pend_t = tgt;
        m_mis    = bad;
      end
    end else begin
      if (m_pend) m_pc = m_pend_t;
      else if (red) begin
        m_pc  = tgt;
        m_mis = bad;
      end else m_pc = m_pc + 4;
      m_pend = 1'b0;
      m_busy = !stall;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".valid"}, {31'h0, fetch_valid}, {31'h0, m_busy});
    check({tag, ".mis"}, {31'h0, misaligned}, {31'h0, m_mis});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic no_redirect();
    jump = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump = 1'b1;
    jump_target = t;
  endtask

  task automatic do_branch(input logic [31:0] b, input logic [31:0] o);
    branch_taken = 1'b1;
    branch_base = b;
    offset_shifted = o;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    imem_ready = 1'b1;
    branch_base = 32'h0;
    offset_shifted = 32'h0;
    jump_target = 32'h0;
    no_redirect();
    model_reset();
    #3;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release: fetch starts on the next edge and then streams 0, 4, 8, 12.
    step("start");
    check("first_valid", {31'h0, fetch_valid}, 32'd1);
    check("seq0", pc, 32'h0);
    step("seq4");
    check("seq4_pc", pc, 32'h4);
    step("seq8");
    step("seq12");
    check("seq12_pc", pc, 32'hC);

    // A branch sum wraps modulo 2^32. A jump in the same cycle wins.
    do_branch(32'h104, 32'hFFFF_FFF0);
    step("branch");
    check("branch_pc", pc, 32'hF4);
    do_jump(32'h200);
    step("jump_prio");
    check("jump_prio_pc", pc, 32'h200);
    no_redirect();

    // Outstanding request at 0x40: the first redirect is parked; the later branch is dropped.
    do_jump(32'h40);
    step("to40");
    no_redirect();
    imem_ready = 1'b0;
    do_jump(32'h300);
    step("wait1");
    no_redirect();
    do_branch(32'h400, 32'h100);
    step("wait2");
    no_redirect();
    step("wait3");
    check("hold40", pc, 32'h40);
    imem_ready = 1'b1;
    step("accept");
    check("pend300", pc, 32'h300);

    // A stall during an accepted fetch enters HOLD. A redirect in HOLD loads pc directly.
    do_jump(32'h10);
    step("to10");
    no_redirect();
    stall = 1'b1;
    step("stall_acc");
    check("hold14", pc, 32'h14);
    check("hold_novalid", {31'h0, fetch_valid}, 32'd0);
    step("hold2");
    do_branch(32'h80, 32'h0);
    step("hold_branch");
    check("hold80", pc, 32'h80);
    no_redirect();
    stall = 1'b0;
    step("resume");
    check("resume_valid", {31'h0, fetch_valid}, 32'd1);
    check("resume_pc", pc, 32'h80);

    // Wrap-around of pc_plus4, and a misaligned jump that yields a single pulse.
    do_jump(32'hFFFF_FFFC);
    step("tofffc");
    no_redirect();
    check("wrap_pc4", pc_plus4, 32'h0);
    step("wrap");
    check("wrap_pc", pc, 32'h0);
    do_jump(32'h1236);
    step("misjump");
    no_redirect();
    check("mis_pc", pc, 32'h1234);
    check("mis_pulse", {31'h0, misaligned}, 32'd1);
    step("mis_clear");
    check("mis_once", {31'h0, misaligned}, 32'd0);

    // Asynchronous reset while a redirect is parked. The parked redirect must never apply.
    imem_ready = 1'b0;
    do_jump(32'h700);
    step("park700");
    no_redirect();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_pc", pc, 32'h0);
    check("async_valid", {31'h0, fetch_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    step("rst_start");
    step("rst_seq");
    check("no_stale_pend", pc, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      imem_ready     = ($urandom_range(0, 2) != 0);
      branch_taken   = ($urandom_range(0, 4) == 0);
      jump           = ($urandom_range(0, 5) == 0);
      branch_base    = $urandom;
      offset_shifted = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      jump_target    = $urandom;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
